// File: rtl/fault_scan_encoder.sv
// Fault scan encoder: grants up to MAX_GRANTS matching cell indices per scan over a valid/ready port.
// Optional build macro FAULT_SCAN_COUNT_EN adds a match_count output holding the popcount of the scanned match vector.
module fault_scan_encoder #(
  parameter int INPUT_WIDTH = 8,
  parameter int ENCODED_VAL = 0,
  parameter int MSB_FIRST   = 0,
  parameter int MAX_GRANTS  = 2,
  localparam int NUM_ENCODED_BITS = $clog2(INPUT_WIDTH),
  localparam int CNT_W            = $clog2(MAX_GRANTS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [INPUT_WIDTH-1:0]      data_in,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_ENCODED_BITS-1:0] encoded_out,
  output logic [CNT_W-1:0]            grant_count,
  output logic                        done,
`ifdef FAULT_SCAN_COUNT_EN
  output logic [$clog2(INPUT_WIDTH+1)-1:0] match_count,
`endif
  output logic                        overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]      pending_q, pending_d;
  logic [NUM_ENCODED_BITS-1:0] enc_q, enc_d;
  logic                        vld_q, vld_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic [INPUT_WIDTH-1:0]      match_vec;

  // Index of the first pending cell in the configured priority direction.
  function automatic logic [NUM_ENCODED_BITS-1:0] prio_idx(input logic [INPUT_WIDTH-1:0] v);
    prio_idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < INPUT_WIDTH; i++)
        if (v[i]) prio_idx = NUM_ENCODED_BITS'(i);
    end else begin
      for (int i = INPUT_WIDTH - 1; i >= 0; i--)
        if (v[i]) prio_idx = NUM_ENCODED_BITS'(i);
    end
  endfunction

  assign match_vec = (ENCODED_VAL != 0) ? data_in : ~data_in;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    enc_d     = enc_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = match_vec;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (pending_q == '0) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(MAX_GRANTS)) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          enc_d   = prio_idx(pending_q);
          vld_d   = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (vld_q && out_ready) begin
          pending_d[enc_q] = 1'b0;
          cnt_d            = cnt_q + CNT_W'(1);
          vld_d            = 1'b0;
          state_d          = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      enc_q     <= '0;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enc_q     <= enc_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef FAULT_SCAN_COUNT_EN
  logic [$clog2(INPUT_WIDTH+1)-1:0] mcnt_q;

  function automatic logic [$clog2(INPUT_WIDTH+1)-1:0] popcount(input logic [INPUT_WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < INPUT_WIDTH; i++)
      popcount = popcount + {{($clog2(INPUT_WIDTH+1)-1){1'b0}}, v[i]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mcnt_q <= '0;
    else if (state_q == IDLE && start)
      mcnt_q <= popcount(match_vec);
  end

  assign match_count = mcnt_q;
`endif

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign out_valid   = vld_q;
  assign encoded_out = enc_q;
  assign grant_count = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fault_scan_encoder.sv
// Scoreboard bench: an LSB-first and an MSB-first encoder share stimulus; monitors check each against its own queue.
module tb_fault_scan_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       out_ready;

  logic       busy_a, vld_a, done_a, ovf_a;
  logic [2:0] enc_a;
  logic [1:0] gc_a;
  logic       busy_b, vld_b, done_b, ovf_b;
  logic [2:0] enc_b;
  logic [1:0] gc_b;
`ifdef FAULT_SCAN_COUNT_EN
  logic [3:0] mc_a, mc_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit is_done;
    int val;
    int gc;
    int ov;
    int mc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  fault_scan_encoder #(.INPUT_WIDTH(8), .ENCODED_VAL(0), .MSB_FIRST(0), .MAX_GRANTS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy_a), .out_valid(vld_a), .out_ready(out_ready), .encoded_out(enc_a),
    .grant_count(gc_a), .done(done_a),
`ifdef FAULT_SCAN_COUNT_EN
    .match_count(mc_a),
`endif
    .overflow(ovf_a));

  fault_scan_encoder #(.INPUT_WIDTH(8), .ENCODED_VAL(0), .MSB_FIRST(1), .MAX_GRANTS(2)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy_b), .out_valid(vld_b), .out_ready(out_ready), .encoded_out(enc_b),
    .grant_count(gc_b), .done(done_b),
`ifdef FAULT_SCAN_COUNT_EN
    .match_count(mc_b),
`endif
    .overflow(ovf_b));

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit d, input int v, input int g, input int o, input int m);
    exp_t e;
    e.is_done = d; e.val = v; e.gc = g; e.ov = o; e.mc = m;
    return e;
  endfunction

  // Monitor for the LSB-first instance.
  always @(negedge clk) begin
    if (!rst && ((vld_a && out_ready) || done_a)) begin
      if (qa.size() == 0) begin
        check("lsb_unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("lsb_event_kind", int'(done_a), int'(e.is_done));
        if (!e.is_done) check("lsb_index", int'(enc_a), e.val);
        else begin
          check("lsb_done_grant_count", int'(gc_a), e.gc);
          check("lsb_done_overflow", int'(ovf_a), e.ov);
`ifdef FAULT_SCAN_COUNT_EN
          check("lsb_match_count", int'(mc_a), e.mc);
`endif
        end
      end
    end
  end

  // Monitor for the MSB-first instance.
  always @(negedge clk) begin
    if (!rst && ((vld_b && out_ready) || done_b)) begin
      if (qb.size() == 0) begin
        check("msb_unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("msb_event_kind", int'(done_b), int'(e.is_done));
        if (!e.is_done) check("msb_index", int'(enc_b), e.val);
        else begin
          check("msb_done_grant_count", int'(gc_b), e.gc);
          check("msb_done_overflow", int'(ovf_b), e.ov);
`ifdef FAULT_SCAN_COUNT_EN
          check("msb_match_count", int'(mc_b), e.mc);
`endif
        end
      end
    end
  end

  // Pulses start for one cycle; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_a) begin got = 1; break; end
      @(negedge clk);
    end
    check({name, "_done_seen"}, int'(got), 1);
    @(negedge clk);
    check({name, "_idle_after_done"}, int'(busy_a), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy_a), 0);
    check("reset_out_valid", int'(vld_a), 0);
    check("reset_encoded", int'(enc_a), 0);
    check("reset_grant_count", int'(gc_a), 0);
    check("reset_done", int'(done_a), 0);
    check("reset_overflow", int'(ovf_a), 0);
    rst = 1'b0;

    // Two zero cells at 1 and 3.
    qa.push_back(mk(0, 1, 0, 0, 0)); qa.push_back(mk(0, 3, 0, 0, 0)); qa.push_back(mk(1, 0, 2, 0, 2));
    qb.push_back(mk(0, 3, 0, 0, 0)); qb.push_back(mk(0, 1, 0, 0, 0)); qb.push_back(mk(1, 0, 2, 0, 2));
    do_start(8'b1111_0101);
    check("t1_scan_busy", int'(busy_a), 1);
    check("t1_scan_no_valid", int'(vld_a), 0);
    @(negedge clk);
    check("t1_first_valid_latency", int'(vld_a), 1);
    wait_done("t1");

    // No match: done two cycles after start, nothing emitted.
    qa.push_back(mk(1, 0, 0, 0, 0));
    qb.push_back(mk(1, 0, 0, 0, 0));
    do_start(8'hFF);
    check("t2_no_valid", int'(vld_a), 0);
    @(negedge clk);
    check("t2_done_latency", int'(done_a), 1);
    check("t2_never_valid", int'(vld_a), 0);
    wait_done("t2");

    // All cells match: spares exhausted.
    qa.push_back(mk(0, 0, 0, 0, 0)); qa.push_back(mk(0, 1, 0, 0, 0)); qa.push_back(mk(1, 0, 2, 1, 8));
    qb.push_back(mk(0, 7, 0, 0, 0)); qb.push_back(mk(0, 6, 0, 0, 0)); qb.push_back(mk(1, 0, 2, 1, 8));
    do_start(8'h00);
    wait_done("t3");
    repeat (2) @(negedge clk);
    check("t3_hold_grant_count", int'(gc_a), 2);
    check("t3_hold_overflow", int'(ovf_a), 1);

    // Zeros at both ends.
    qa.push_back(mk(0, 0, 0, 0, 0)); qa.push_back(mk(0, 7, 0, 0, 0)); qa.push_back(mk(1, 0, 2, 0, 2));
    qb.push_back(mk(0, 7, 0, 0, 0)); qb.push_back(mk(0, 0, 0, 0, 0)); qb.push_back(mk(1, 0, 2, 0, 2));
    do_start(8'b0111_1110);
    wait_done("t4");

    // Back-pressure with ignored start pulses.
    qa.push_back(mk(0, 4, 0, 0, 0)); qa.push_back(mk(1, 0, 1, 0, 1));
    qb.push_back(mk(0, 4, 0, 0, 0)); qb.push_back(mk(1, 0, 1, 0, 1));
    out_ready = 1'b0;
    do_start(8'b1110_1111);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t5_stall_valid", int'(vld_a), 1);
      check("t5_stall_index", int'(enc_a), 4);
      if (i == 3) begin data_in = 8'h00; start = 1'b1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done("t5");

    // Reset while emitting discards the scan.
    out_ready = 1'b0;
    do_start(8'b1111_0101);
    @(negedge clk);
    check("t6_in_emit", int'(vld_a), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", int'(busy_a), 0);
    check("t6_rst_valid", int'(vld_a), 0);
    check("t6_rst_encoded", int'(enc_a), 0);
    check("t6_rst_grant_count", int'(gc_a), 0);
    check("t6_rst_done", int'(done_a), 0);
    check("t6_rst_overflow", int'(ovf_a), 0);
    qa.delete(); qb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_done_after_rst", int'(done_a | done_b), 0);
    end
    qa.push_back(mk(0, 1, 0, 0, 0)); qa.push_back(mk(0, 3, 0, 0, 0)); qa.push_back(mk(1, 0, 2, 0, 2));
    qb.push_back(mk(0, 3, 0, 0, 0)); qb.push_back(mk(0, 1, 0, 0, 0)); qb.push_back(mk(1, 0, 2, 0, 2));
    do_start(8'b1111_0101);
    wait_done("t6_rescan");

    repeat (2) @(negedge clk);
    check("lsb_queue_drained", qa.size(), 0);
    check("msb_queue_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
